// File: rtl/astro_led_pkg.sv
// Shared types for the status LED scheduler: per-unit progress states and
// RGB colour codes in R,G,B bit order.
package astro_led_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    ACTIVE = 3'd1,
    FAULT  = 3'd2,
    PICKED = 3'd3,
    DONE   = 3'd4
  } unit_state;

  localparam int NUM_UNITS = 3;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  function automatic logic [2:0] state_colour(input unit_state st, input logic phase);
    logic [2:0] c;
    case (st)
      OFF:     c = RGB_OFF;
      ACTIVE:  c = RGB_RED;
      FAULT:   c = RGB_BLUE;
      PICKED:  c = phase ? RGB_BLUE : RGB_OFF;
      DONE:    c = RGB_GREEN;
      default: c = RGB_OFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Free-running blink phase generator; restart forces the visible half so a
// newly started blink begins lit.
module led_blink_timer #(
  parameter int unsigned BLINK_HALF = 3125000
) (
  input  logic clk_3125KHz,
  input  logic rst_n,
  input  logic restart,
  output logic phase
);

  logic [31:0] count_r;

  // Half-period counter; phase flips on each wrap.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 32'd0;
      phase   <= 1'b0;
    end else if (restart) begin
      count_r <= 32'd0;
      phase   <= 1'b1;
    end else if (count_r == BLINK_HALF - 32'd1) begin
      count_r <= 32'd0;
      phase   <= ~phase;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

endmodule

// File: rtl/led_status_scheduler.sv
// Status LED sequencer: one progress FSM per service unit (EU, CU, RU), events
// routed to the selected unit, run-complete green blink override.
module led_status_scheduler
  import astro_led_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 3125000
) (
  input  logic clk_3125KHz,
  input  logic rst_n,
  input  logic EU_fault_flag,
  input  logic CU_fault_flag,
  input  logic RU_fault_flag,
  input  logic fault_detect,
  input  logic block_picked,
  input  logic object_drop,
  input  logic run_complete,
  output logic led1_R1,
  output logic led1_G1,
  output logic led1_B1,
  output logic led2_R2,
  output logic led2_G2,
  output logic led2_B2,
  output logic led3_R3,
  output logic led3_G3,
  output logic led3_B3,
  output logic seq_error,
  output logic run_done
);

  logic      fd_q_r, bp_q_r, od_q_r, rc_q_r;
  logic      fd_edge_s, bp_edge_s, od_edge_s, rc_edge_s;
  logic      ev_fault_s, ev_pick_s, ev_drop_s, any_evt_s;
  logic      frozen_s, err_s, phase_s;
  logic [2:0] sel_s;
  unit_state state_r [NUM_UNITS];
  unit_state next_s  [NUM_UNITS];
  logic [2:0] col_s  [NUM_UNITS];

  assign fd_edge_s = fault_detect & ~fd_q_r;
  assign bp_edge_s = block_picked & ~bp_q_r;
  assign od_edge_s = object_drop  & ~od_q_r;
  assign rc_edge_s = run_complete & ~rc_q_r;

  led_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .restart     (rc_edge_s & ~run_done),
    .phase       (phase_s)
  );

  // Unit select (EU > CU > RU) and event priority (drop > pick > fault).
  always_comb begin
    sel_s = 3'b000;
    if (EU_fault_flag) begin
      sel_s = 3'b001;
    end else if (CU_fault_flag) begin
      sel_s = 3'b010;
    end else if (RU_fault_flag) begin
      sel_s = 3'b100;
    end else begin
      sel_s = 3'b000;
    end
    ev_drop_s  = od_edge_s;
    ev_pick_s  = bp_edge_s & ~od_edge_s;
    ev_fault_s = fd_edge_s & ~od_edge_s & ~bp_edge_s;
    any_evt_s  = od_edge_s | bp_edge_s | fd_edge_s;
    frozen_s   = run_done | rc_edge_s;
  end

  // Per-unit next state; only the selected unit sees events.
  always_comb begin
    err_s = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      next_s[u] = state_r[u];
      if (!frozen_s && sel_s[u]) begin
        case (state_r[u])
          OFF: begin
            next_s[u] = ACTIVE;
            err_s     = err_s | any_evt_s;
          end
          ACTIVE: begin
            if (ev_fault_s) next_s[u] = FAULT;
            else            err_s     = err_s | any_evt_s;
          end
          FAULT: begin
            if (ev_pick_s) next_s[u] = PICKED;
            else           err_s     = err_s | any_evt_s;
          end
          PICKED: begin
            if (ev_drop_s) next_s[u] = DONE;
            else           err_s     = err_s | any_evt_s;
          end
          DONE:    err_s     = err_s | any_evt_s;
          default: next_s[u] = OFF;
        endcase
      end else begin
        next_s[u] = state_r[u];
      end
    end
  end

  // Colour per LED; run-done blink overrides every unit.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (run_done) col_s[u] = {1'b0, phase_s, 1'b0};
      else          col_s[u] = state_colour(state_r[u], phase_s);
    end
  end

  // State, edge history and status flags.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UNITS; u++) state_r[u] <= OFF;
      fd_q_r    <= 1'b0;
      bp_q_r    <= 1'b0;
      od_q_r    <= 1'b0;
      rc_q_r    <= 1'b0;
      seq_error <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) state_r[u] <= next_s[u];
      fd_q_r    <= fault_detect;
      bp_q_r    <= block_picked;
      od_q_r    <= object_drop;
      rc_q_r    <= run_complete;
      seq_error <= err_s;
      run_done  <= run_done | rc_edge_s;
    end
  end

  // Registered LED pins.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      {led1_R1, led1_G1, led1_B1} <= RGB_OFF;
      {led2_R2, led2_G2, led2_B2} <= RGB_OFF;
      {led3_R3, led3_G3, led3_B3} <= RGB_OFF;
    end else begin
      {led1_R1, led1_G1, led1_B1} <= col_s[0];
      {led2_R2, led2_G2, led2_B2} <= col_s[1];
      {led3_R3, led3_G3, led3_B3} <= col_s[2];
    end
  end

endmodule
